// File: rtl/counter_slot_scheduler.sv
// counter_slot_scheduler: one 0..MAX_LIMIT up-counter shared between N
// requesters. The block arbitrates among the active requests, grants the
// counter to one owner, counts from 0 up to that owner's clamped terminal
// value, and then pulses done to the owner for one cycle.
// Optional build macro RR_ARB_EN: when defined, arbitration is round-robin
// from a rotating pointer. When undefined, the lowest set index wins and no
// pointer register is built.
module counter_slot_scheduler #(
  parameter int N         = 4,
  parameter int W         = 7,
  parameter int MAX_LIMIT = 100
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] limit_i,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [W-1:0]   count_o,
  output logic           busy
);

  localparam int               IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0]     MAX_L = W'(MAX_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [W-1:0]       lim_q, lim_d;
  logic [W-1:0]       count_q, count_d;

  logic [IDX_W-1:0]   win;
  logic               win_found;
  logic [W-1:0]       win_raw;
  logic [W-1:0]       win_lim;

`ifdef RR_ARB_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_next;

  // Index after the current owner, wrapping modulo N.
  assign owner_next = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

  // Round-robin search: first set request at or after the pointer wins.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!win_found && req[(int'(ptr_q) + i) % N]) begin
        win_found = 1'b1;
        win       = IDX_W'((int'(ptr_q) + i) % N);
      end
    end
  end
`else
  // Fixed priority search: lowest set request index wins.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!win_found && req[i]) begin
        win_found = 1'b1;
        win       = IDX_W'(i);
      end
    end
  end
`endif

  // Winner's terminal count, clamped so the counter never passes MAX_LIMIT.
  assign win_raw = limit_i[win*W +: W];
  assign win_lim = (win_raw > MAX_L) ? MAX_L : win_raw;

  // Next-state logic for the IDLE -> RUN -> DONE sequence and the counter.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d = state_q;
    owner_d = owner_q;
    lim_d   = lim_q;
    count_d = count_q;
`ifdef RR_ARB_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (win_found) begin
          state_d = S_RUN;
          owner_d = win;
          lim_d   = win_lim;
        end
      end
      S_RUN: begin
        // Abort outranks a terminal match in the same cycle.
        if (!req[owner_q]) begin
          state_d = S_IDLE;
          count_d = '0;
`ifdef RR_ARB_EN
          ptr_d   = owner_next;
`endif
        end else if (count_q == lim_q) begin
          state_d = S_DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        count_d = '0;
`ifdef RR_ARB_EN
        ptr_d   = owner_next;
`endif
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      lim_q   <= '0;
      count_q <= '0;
`ifdef RR_ARB_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lim_q   <= lim_d;
      count_q <= count_d;
`ifdef RR_ARB_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign gnt     = busy ? (N'(1) << owner_q) : '0;
  assign done    = (state_q == S_DONE) ? gnt : '0;
  assign count_o = count_q;

endmodule

// File: tb/tb_counter_slot_scheduler.sv
// Directed bench for counter_slot_scheduler with hand-computed expectations.
module tb_counter_slot_scheduler;

  localparam int N = 4;
  localparam int W = 7;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] limit_i;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [W-1:0]   count_o;
  logic           busy;

  int total = 0;
  int bad   = 0;

  counter_slot_scheduler #(.N(N), .W(W), .MAX_LIMIT(100)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .limit_i (limit_i),
    .gnt     (gnt),
    .done    (done),
    .count_o (count_o),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic set_limit(input int idx, input logic [W-1:0] v);
    limit_i[idx*W +: W] = v;
  endtask

  // Packs all outputs so an idle check is a single comparison against zero.
  function automatic logic [31:0] outs();
    return {16'd0, busy, count_o, done, gnt};
  endfunction

  logic [N-1:0] exp_own;

  initial begin
    rst     = 1'b0;
    req     = '0;
    limit_i = '0;

    // 1: reset then quiet idle for 10 cycles
    do_reset();
    check("reset_outs", outs(), 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("idle_hold", outs(), 32'd0);
    end

    // 2: requester 0, limit 5; later limit change must be ignored
    set_limit(0, 7'd5);
    req = 4'b0001;
    tick();
    check("r0_gnt", {busy, count_o, gnt}, {1'b1, 7'd0, 4'b0001});
    set_limit(0, 7'd1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("r0_cnt", {done, count_o}, 32'(k));
    end
    tick();
    check("r0_done", {gnt, done, count_o}, {4'b0001, 4'b0001, 7'd5});
    req = 4'b0000;
    tick();
    check("r0_idle", outs(), 32'd0);

    // 3a: limit 0 -> one RUN cycle at count 0, then done
    set_limit(1, 7'd0);
    req = 4'b0010;
    tick();
    check("l0_gnt", {busy, count_o, done, gnt}, {1'b1, 7'd0, 4'b0000, 4'b0010});
    tick();
    check("l0_done", {count_o, done}, {7'd0, 4'b0010});
    req = 4'b0000;
    tick();
    check("l0_idle", outs(), 32'd0);

    // 3b: limit 127 clamps to 100
    set_limit(1, 7'd127);
    req = 4'b0010;
    tick();
    check("clamp_gnt", gnt, 4'b0010);
    for (int k = 1; k <= 100; k++) begin
      tick();
      check("clamp_cnt", {done, count_o}, 32'(k));
    end
    tick();
    check("clamp_done", {done, count_o}, {4'b0010, 7'd100});
    req = 4'b0000;
    tick();
    check("clamp_idle", outs(), 32'd0);

    // 4: req 0101 held, limits 2; RR alternates 0,2 and fixed picks 0
    do_reset();
    for (int i = 0; i < N; i++) set_limit(i, 7'd2);
    req = 4'b0101;
    for (int r = 0; r < 4; r++) begin
`ifdef RR_ARB_EN
      exp_own = (r % 2 == 1) ? 4'b0100 : 4'b0001;
`else
      exp_own = 4'b0001;
`endif
      tick();
      check("arb_gnt", gnt, 32'(exp_own));
      tick();
      tick();
      check("arb_cnt2", {done, count_o}, 32'd2);
      tick();
      check("arb_done", {gnt, done}, {exp_own, exp_own});
      tick();
      check("arb_gap", outs(), 32'd0);
    end
    req = 4'b0000;
    tick();

    // 5: requester 3 aborts at count 3; pending req0 granted next
    do_reset();
    set_limit(3, 7'd10);
    set_limit(0, 7'd4);
    req = 4'b1000;
    tick();
    check("ab_gnt", gnt, 4'b1000);
    tick();
    tick();
    tick();
    check("ab_cnt3", count_o, 7'd3);
    req = 4'b0001;
    tick();
    check("ab_idle", outs(), 32'd0);
    tick();
    check("ab_next", {busy, count_o, gnt}, {1'b1, 7'd0, 4'b0001});
    req = 4'b0000;
    tick();
    check("ab_idle2", outs(), 32'd0);

    // 5b: abort beats terminal match when limit is 0
    set_limit(1, 7'd0);
    req = 4'b0010;
    tick();
    check("abt_gnt", gnt, 4'b0010);
    req = 4'b0000;
    tick();
    check("abt_nodone", outs(), 32'd0);

    // 6: reset during RUN at count 50, then fresh restart
    set_limit(2, 7'd120);
    req = 4'b0100;
    tick();
    check("mr_gnt", gnt, 4'b0100);
    for (int k = 0; k < 50; k++) tick();
    check("mr_cnt50", count_o, 7'd50);
    rst = 1'b0;
    tick();
    check("mr_reset", outs(), 32'd0);
    rst = 1'b1;
    tick();
    check("mr_regnt", {busy, count_o, gnt}, {1'b1, 7'd0, 4'b0100});
    tick();
    check("mr_cnt1", count_o, 7'd1);
    req = 4'b0000;
    tick();
    check("mr_idle", outs(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
